// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state and owner types for mem_arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - one-outstanding arbiter sharing a memory port between fetch and load/store
// MEM_ARB_RR_EN: round-robin tie-break instead of fixed data priority
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall
);

  arb_state_t state;
  owner_t     owner;
  owner_t     winner;

`ifdef MEM_ARB_RR_EN
  owner_t last_owner;

  always_comb begin
    winner = OWN_IF;
    if (d_req && (!if_req || last_owner == OWN_IF)) winner = OWN_D;
  end

  // Resets to D so the first tie after reset is handed to the fetch side.
  always_ff @(posedge clk) begin
    if (rst) last_owner <= OWN_D;
    else if (state == IDLE && (if_req || d_req)) last_owner <= winner;
  end
`else
  assign winner = d_req ? OWN_D : OWN_IF;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            owner <= winner;
            state <= ISSUE;
            if (winner == OWN_D) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_be    <= d_be;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_be    <= '1;
            end
          end
        end
        ISSUE: if (mem_gnt) state <= WAIT;
        WAIT: begin
          if (mem_rvalid) begin
            state <= DONE;
            // A store's rvalid is only an acknowledge; d_rdata keeps the last load.
            if (owner == OWN_IF) if_rdata <= mem_rdata;
            else if (!mem_we)    d_rdata  <= mem_rdata;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req = (state == ISSUE);
  assign if_done = (state == DONE) && (owner == OWN_IF);
  assign d_done  = (state == DONE) && (owner == OWN_D);
  assign stall   = (if_req && !if_done) || (d_req && !d_done);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a transaction model
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [BW-1:0] d_be = '0;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          stall;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall(stall)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: grant after gnt_delay ISSUE cycles, respond rsp_delay cycles after the earliest legal one.
  bit            rand_mem = 1'b0;
  int            gnt_delay = 0;
  int            rsp_delay = 0;
  int            gnt_cnt = 0;
  int            rsp_cnt = 0;
  bit            p_pend = 1'b0;
  logic          p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic [BW-1:0] p_be;
  logic [DW-1:0] store [logic [AW-1:0]];

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (store.exists(a)) return store[a];
    return (a * 32'h9E37_79B9) ^ 32'h0F0F_1234;
  endfunction

  task automatic drive_mem();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (p_pend) begin
      if (rsp_cnt >= rsp_delay) begin
        mem_rvalid = 1'b1;
        mem_rdata  = p_we ? $urandom : mem_rd(p_addr);
      end else rsp_cnt++;
    end else if (mem_req === 1'b1) begin
      if (gnt_cnt >= gnt_delay) mem_gnt = 1'b1;
      else gnt_cnt++;
    end
  endtask

  task automatic mem_edge();
    logic [DW-1:0] w;
    if (rst) begin
      p_pend = 1'b0; gnt_cnt = 0; rsp_cnt = 0;
    end else if (mem_rvalid) begin
      if (p_we) begin
        w = mem_rd(p_addr);
        for (int b = 0; b < BW; b++) if (p_be[b]) w[8*b +: 8] = p_wdata[8*b +: 8];
        store[p_addr] = w;
      end
      p_pend = 1'b0; rsp_cnt = 0;
      if (rand_mem) rsp_delay = $urandom_range(0, 3);
    end else if (mem_gnt) begin
      p_pend = 1'b1; p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata; p_be = mem_be;
      gnt_cnt = 0;
      if (rand_mem) gnt_delay = $urandom_range(0, 3);
    end
  endtask

  // Transaction model: one outstanding access, tracked as busy / granted / responded flags.
  bit            x_busy, x_own_d, x_granted, x_responded, x_last_d;
  logic          x_we;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wdata, x_if_rdata, x_d_rdata;
  logic [BW-1:0] x_be;

  task automatic model_edge();
    if (rst) begin
      x_busy = 0; x_granted = 0; x_responded = 0; x_own_d = 0; x_last_d = 1;
      x_we = 0; x_addr = '0; x_wdata = '0; x_be = '0; x_if_rdata = '0; x_d_rdata = '0;
    end else if (x_busy && x_responded) begin
      x_busy = 0;
    end else if (!x_busy) begin
      if (if_req || d_req) begin
`ifdef MEM_ARB_RR_EN
        x_own_d  = d_req && (!if_req || !x_last_d);
        x_last_d = x_own_d;
`else
        x_own_d = d_req;
`endif
        if (x_own_d) begin
          x_we = d_we; x_addr = d_addr; x_wdata = d_wdata; x_be = d_be;
        end else begin
          x_we = 1'b0; x_addr = if_addr; x_be = '1;
        end
        x_busy = 1; x_granted = 0; x_responded = 0;
      end
    end else if (!x_granted) begin
      x_granted = mem_gnt;
    end else if (mem_rvalid) begin
      x_responded = 1;
      if (!x_own_d) x_if_rdata = mem_rdata;
      else if (!x_we) x_d_rdata = mem_rdata;
    end
  endtask

  task automatic compare();
    bit e_if, e_d;
    e_if = x_busy && x_responded && !x_own_d;
    e_d  = x_busy && x_responded && x_own_d;
    chk("if_done", 64'(if_done), 64'(e_if));
    chk("d_done", 64'(d_done), 64'(e_d));
    chk("mem_req", 64'(mem_req), 64'(x_busy && !x_granted));
    chk("if_rdata", 64'(if_rdata), 64'(x_if_rdata));
    chk("d_rdata", 64'(d_rdata), 64'(x_d_rdata));
    chk("stall", 64'(stall), 64'((if_req && !e_if) || (d_req && !e_d)));
    if (x_busy) begin
      chk("mem_we", 64'(mem_we), 64'(x_we));
      chk("mem_addr", 64'(mem_addr), 64'(x_addr));
      if (x_we) chk("mem_wdata", 64'(mem_wdata), 64'(x_wdata));
      if (x_we || !x_own_d) chk("mem_be", 64'(mem_be), 64'(x_be));
    end
  endtask

  bit rand_req = 1'b0;

  task automatic drive_reqs();
    if (!rand_req) return;
    if (if_req && if_done) if_req = 1'b0;
    if (d_req && d_done) d_req = 1'b0;
    if (!if_req && $urandom_range(0, 2) == 0) begin
      if_req = 1'b1; if_addr = AW'($urandom_range(0, 63)) << 2;
    end
    if (!d_req && $urandom_range(0, 2) == 0) begin
      d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = AW'($urandom_range(0, 63)) << 2;
      d_wdata = $urandom; d_be = BW'($urandom_range(1, 15));
    end
  endtask

  task automatic step();
    drive_reqs();
    drive_mem();
    model_edge();
    mem_edge();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    compare();
  endtask

  task automatic wait_done(input bit want_d, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (want_d ? d_done : if_done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL timeout waiting for %s done: got none, expected within %0d cycles", want_d ? "d" : "if", budget);
    end
  endtask

  logic [DW-1:0] b2b_val [3] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113};
  int            t0, at;
  bit            first_d;
  logic [DW-1:0] exp_word;

  initial begin
    @(negedge clk);
    step();
    step();
    chk("reset_mem_req", 64'(mem_req), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    chk("reset_if_rdata", 64'(if_rdata), 64'd0);
    chk("reset_d_rdata", 64'(d_rdata), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    rst = 1'b0;

    // Fetch at minimum latency
    store[32'h10] = 32'h0050_0093;
    if_addr = 32'h10; if_req = 1'b1; t0 = cyc;
    step();
    chk("fetch_mem_we", 64'(mem_we), 64'd0);
    chk("fetch_mem_be", 64'(mem_be), 64'hF);
    chk("fetch_stall", 64'(stall), 64'd1);
    wait_done(1'b0, 10, at);
    chk("fetch_latency", 64'(at - t0), 64'd3);
    chk("fetch_rdata", 64'(if_rdata), 64'h0050_0093);
    chk("fetch_stall_done", 64'(stall), 64'd0);
    if_req = 1'b0;
    step();

    // Simultaneous requests straight after reset
    rst = 1'b1; step(); rst = 1'b0;
    store[32'h100] = 32'hDEAD_BEEF;
    if_addr = 32'h20; d_addr = 32'h100; d_we = 1'b0; d_be = 4'h0;
    if_req = 1'b1; d_req = 1'b1; t0 = cyc;
`ifdef MEM_ARB_RR_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    wait_done(first_d, 10, at);
    chk("tie_first_latency", 64'(at - t0), 64'd3);
    if (first_d) d_req = 1'b0; else if_req = 1'b0;
    wait_done(!first_d, 10, at);
    chk("tie_second_latency", 64'(at - t0), 64'd7);
    if (first_d) if_req = 1'b0; else d_req = 1'b0;
    chk("tie_d_rdata", 64'(d_rdata), 64'hDEAD_BEEF);
    step();

    // Store with three cycles of grant backpressure
    gnt_delay = 3;
    d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234_5678; d_be = 4'b0011;
    d_req = 1'b1; t0 = cyc;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("store_mem_req", 64'(mem_req), 64'd1);
      chk("store_mem_addr", 64'(mem_addr), 64'h200);
      chk("store_mem_wdata", 64'(mem_wdata), 64'h1234_5678);
      chk("store_mem_be", 64'(mem_be), 64'h3);
      chk("store_mem_we", 64'(mem_we), 64'd1);
      step();
    end
    gnt_delay = 0;
    wait_done(1'b1, 12, at);
    chk("store_latency", 64'(at - t0), 64'd6);
    chk("store_d_rdata_kept", 64'(d_rdata), 64'hDEAD_BEEF);
    d_req = 1'b0; d_we = 1'b0;
    step();

    // Reset while waiting for a response
    rsp_delay = 5;
    if_addr = 32'h40; if_req = 1'b1;
    step();
    step();
    rst = 1'b1; if_req = 1'b0;
    step();
    rst = 1'b0; rsp_delay = 0;
    chk("midrst_mem_req", 64'(mem_req), 64'd0);
    chk("midrst_if_rdata", 64'(if_rdata), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_no_done", 64'(if_done || d_done), 64'd0);
    end
    if_req = 1'b1; t0 = cyc;
    wait_done(1'b0, 10, at);
    chk("midrst_refetch_latency", 64'(at - t0), 64'd3);
    exp_word = mem_rd(32'h40);
    chk("midrst_refetch_rdata", 64'(if_rdata), 64'(exp_word));
    if_req = 1'b0;
    step();

    // Back-to-back fetches
    store[32'h0] = b2b_val[0];
    store[32'h4] = b2b_val[1];
    store[32'h8] = b2b_val[2];
    if_addr = 32'h0; if_req = 1'b1; t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      wait_done(1'b0, 10, at);
      chk("b2b_latency", 64'(at - t0), 64'(3 + 4 * k));
      chk("b2b_rdata", 64'(if_rdata), 64'(b2b_val[k]));
      if (k == 2) if_req = 1'b0;
      else if_addr = if_addr + 32'h4;
    end
    step();

    // Randomized traffic and memory timing
    rand_req = 1'b1; rand_mem = 1'b1;
    for (int i = 0; i < 3000; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
